wb_mask_encoder: RTL and testbench

//  - Sequential inverse of the register-file write-enable decoder: accepts a one-hot-or-multi-hot

---
 rtl/wb_enc_pkg.sv | 22 ++
 rtl/ffs_encoder.sv | 31 +++
 rtl/wb_mask_encoder.sv | 132 +++++++++++++
 tb/tb_wb_mask_encoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_enc_pkg.sv
// ============================================================================
// Module  : wb_enc_pkg
// Brief   : Shared types and default sizing for the write-back mask encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_enc_pkg;

    localparam int DEF_REGNUM  = 32;
    localparam int DEF_KEY_LEN = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wb_enc_state_t;

    typedef logic [DEF_KEY_LEN-1:0] reg_idx_t;

endpackage

`default_nettype wire

// File: rtl/ffs_encoder.sv
// ============================================================================
// Module  : ffs_encoder
// Brief   : Combinational find-first-set; reports the lowest set bit index.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ffs_encoder #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_mask_encoder.sv
// ============================================================================
// Module  : wb_mask_encoder
// Brief   : Drains a multi-hot write mask as a stream of register indices.
//           Define WB_ENC_RR_EN for round-robin grant order (default: lowest first).
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_mask_encoder
    import wb_enc_pkg::*;
#(
    parameter int REGNUM  = DEF_REGNUM,
    parameter int KEY_LEN = DEF_KEY_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [REGNUM-1:0]  in_mask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [KEY_LEN-1:0] out_idx,
    output logic               out_last,
    output logic               busy
);

    if (KEY_LEN != $clog2(REGNUM)) begin : g_key_len_check
        $error("wb_mask_encoder: KEY_LEN must equal $clog2(REGNUM)");
    end

    wb_enc_state_t      state_q, state_d;
    logic [REGNUM-1:0]  pending_q, pending_d;
    logic [REGNUM-1:0]  search_vec;
    logic [KEY_LEN-1:0] enc_idx;
    logic [KEY_LEN-1:0] grant_idx;
    logic               found;
    logic               hs;

`ifdef WB_ENC_RR_EN
    logic [KEY_LEN-1:0]  rr_q, rr_d;
    logic [KEY_LEN-1:0]  start;
    logic [2*REGNUM-1:0] dbl;
    logic [KEY_LEN:0]    idx_sum;

    // Rotate so the search begins just after the last grant, then undo the rotation.
    assign start      = (rr_q == KEY_LEN'(REGNUM - 1)) ? '0 : rr_q + 1'b1;
    assign dbl        = {pending_q, pending_q} >> start;
    assign search_vec = dbl[REGNUM-1:0];
    assign idx_sum    = {1'b0, enc_idx} + {1'b0, start};
    assign grant_idx  = (idx_sum >= (KEY_LEN+1)'(REGNUM))
                      ? KEY_LEN'(idx_sum - (KEY_LEN+1)'(REGNUM))
                      : idx_sum[KEY_LEN-1:0];

    always_comb begin
        rr_d = rr_q;
        if (hs) begin
            rr_d = out_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= KEY_LEN'(REGNUM - 1);
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign search_vec = pending_q;
    assign grant_idx  = enc_idx;
`endif

    ffs_encoder #(
        .WIDTH (REGNUM),
        .IDX_W (KEY_LEN)
    ) u_ffs (
        .vec_i   (search_vec),
        .found_o (found),
        .idx_o   (enc_idx)
    );

    assign busy      = (state_q == DRAIN);
    assign out_valid = busy;
    assign in_ready  = (state_q == IDLE);
    assign out_idx   = found ? grant_idx : '0;
    assign out_last  = found && ((pending_q & (pending_q - REGNUM'(1))) == '0);
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (in_valid && (in_mask != '0)) begin
                    state_d   = DRAIN;
                    pending_d = in_mask;
                end
            end
            DRAIN: begin
                if (hs) begin
                    pending_d[out_idx] = 1'b0;
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
                // A handshake in the flush cycle still counts for the consumer.
                if (flush) begin
                    state_d   = IDLE;
                    pending_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_mask_encoder.sv
// ============================================================================
// Module  : tb_wb_mask_encoder
// Brief   : Self-checking bench for wb_mask_encoder (either grant order).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_mask_encoder;

    localparam int REGNUM  = 32;
    localparam int KEY_LEN = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [REGNUM-1:0] in_mask = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [KEY_LEN-1:0] out_idx;
    logic              out_last;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    logic [REGNUM-1:0] m_pend;
    int                m_rr;
    int                gq[$];
    bit                lq[$];

    wb_mask_encoder #(.REGNUM(REGNUM), .KEY_LEN(KEY_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [REGNUM-1:0] p, input int rr);
`ifdef WB_ENC_RR_EN
        for (int k = 1; k <= REGNUM; k++) begin
            if (p[(rr + k) % REGNUM]) return (rr + k) % REGNUM;
        end
`else
        for (int j = 0; j < REGNUM; j++) begin
            if (p[j]) return j;
        end
`endif
        return 0;
    endfunction

    function automatic logic [REGNUM-1:0] next_pend(input logic [REGNUM-1:0] p, input int rr);
        logic [REGNUM-1:0] n;
        n = p;
        if (p == '0) begin
            n = in_valid ? in_mask : '0;
        end else if (flush) begin
            n = '0;
        end else if (out_ready) begin
            n[pick(p, rr)] = 1'b0;
        end
        return n;
    endfunction

    // Reference: busy is exactly "some bit still pending".
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= '0;
            m_rr   <= REGNUM - 1;
        end else begin
            m_pend <= next_pend(m_pend, m_rr);
            if (m_pend != '0 && out_ready) m_rr <= pick(m_pend, m_rr);
        end
    end

    always @(negedge clk) begin
        check("out_valid", 64'(out_valid), 64'(m_pend != '0));
        check("busy", 64'(busy), 64'(m_pend != '0));
        check("in_ready", 64'(in_ready), 64'(m_pend == '0));
        check("out_idx", 64'(out_idx), (m_pend != '0) ? 64'(pick(m_pend, m_rr)) : 64'd0);
        check("out_last", 64'(out_last), 64'($countones(m_pend) == 1));
        if (out_valid && out_ready && rst_n) begin
            gq.push_back(int'(out_idx));
            lq.push_back(out_last);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input logic [REGNUM-1:0] m);
        in_valid = 1'b1;
        in_mask  = m;
        cyc();
        in_valid = 1'b0;
        in_mask  = '0;
    endtask

    task automatic check_grants(input string name, input int e0, input int e1, input int e2, input int n);
        int exp[3];
        exp = '{e0, e1, e2};
        check({name, " count"}, 64'(gq.size()), 64'(n));
        for (int i = 0; i < n && i < gq.size(); i++) begin
            check({name, " idx"}, 64'(gq[i]), 64'(exp[i]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        #2;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_idx", 64'(out_idx), 64'd0);
        check("reset out_last", 64'(out_last), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc();

        // Single bit.
        out_ready = 1'b1;
        offer(32'h0000_0400);
        check("single idx", 64'(out_idx), 64'd10);
        check("single last", 64'(out_last), 64'd1);
        cyc();
        check("single in_ready", 64'(in_ready), 64'd1);

`ifndef WB_ENC_RR_EN
        // Multi-bit, lowest first.
        gq.delete(); lq.delete();
        offer(32'h8000_0011);
        cyc(4);
        check_grants("multi", 0, 4, 31, 3);
        if (lq.size() == 3) begin
            check("multi last0", 64'(lq[0]), 64'd0);
            check("multi last1", 64'(lq[1]), 64'd0);
            check("multi last2", 64'(lq[2]), 64'd1);
        end

        // Backpressure hold.
        gq.delete();
        out_ready = 1'b0;
        offer(32'h0000_0006);
        for (int i = 0; i < 3; i++) begin
            check("hold idx", 64'(out_idx), 64'd1);
            cyc();
        end
        out_ready = 1'b1;
        cyc(3);
        check_grants("bp", 1, 2, 0, 2);
`endif

        // Zero mask dropped.
        offer('0);
        check("zero valid", 64'(out_valid), 64'd0);
        check("zero ready", 64'(in_ready), 64'd1);

        // Flush after two grants; the third handshake coincides with flush.
        do_reset();
        gq.delete();
        offer(32'hFFFF_FFFF);
        cyc(2);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("flush valid", 64'(out_valid), 64'd0);
        check("flush ready", 64'(in_ready), 64'd1);
        cyc(3);
        check_grants("flush", 0, 1, 2, 3);

        // Asynchronous reset mid-drain.
        out_ready = 1'b0;
        offer(32'h0000_00F0);
        check("pre-rst valid", 64'(out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async valid", 64'(out_valid), 64'd0);
        check("async busy", 64'(busy), 64'd0);
        check("async idx", 64'(out_idx), 64'd0);
        check("async last", 64'(out_last), 64'd0);
        check("async ready", 64'(in_ready), 64'd1);
        cyc(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc(2);
        check("post-rst valid", 64'(out_valid), 64'd0);

`ifdef WB_ENC_RR_EN
        do_reset();
        gq.delete();
        offer(32'h0000_0009);
        cyc(2);
        check_grants("rr first", 0, 3, 0, 2);
        gq.delete();
        offer(32'h0000_0009);
        cyc(2);
        check_grants("rr wrap", 0, 3, 0, 2);
        gq.delete();
        offer(32'h0000_0011);
        cyc(2);
        check_grants("rr resume", 4, 0, 0, 2);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: in_mask = $urandom & $urandom & $urandom;
                1: in_mask = REGNUM'(1) << $urandom_range(0, REGNUM - 1);
                2: in_mask = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
                default: in_mask = $urandom & $urandom;
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 400) == 0) begin
                #4;
                rst_n = 1'b0;
                #1;
                check("rand async valid", 64'(out_valid), 64'd0);
                cyc();
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
